// File: rtl/alu_sched_if.sv
// Request/response bundle between the two ALU requesters, the consumer and alu_sched.
interface alu_sched_if #(
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [6:0]       req0_a;
    logic [6:0]       req0_b;
    logic [2:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [6:0]       req1_a;
    logic [6:0]       req1_b;
    logic [2:0]       req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [6:0]       rsp_result;
    logic [3:0]       rsp_flags;
    logic             rsp_err;

    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
        output cnt0, cnt1
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
        input  cnt0, cnt1
    );
endinterface

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one 7-bit ALU between two requesters.
// Accept -> EXEC -> registered RESP (3 cycles/op); RESP holds until rsp_ready, no new accepts meanwhile.

module alu_sched_alu (
    input  logic [6:0] a_i,
    input  logic [6:0] b_i,
    input  logic [2:0] op_i,
    output logic [6:0] result_o,
    output logic [3:0] flags_o,
    output logic       err_o
);
    logic [6:0] b_eff;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;

    // Sub reuses the adder as A + ~B + 1, so carry-out means "no borrow".
    assign b_eff = op_i[0] ? ~b_i : b_i;
    assign sum   = {1'b0, a_i} + {1'b0, b_eff} + {7'd0, op_i[0]};

    always_comb begin
        result_o = 7'd0;
        carry    = 1'b0;
        ovf      = 1'b0;
        err_o    = 1'b0;
        case (op_i)
            3'b000, 3'b001: begin
                result_o = sum[6:0];
                carry    = sum[7];
                ovf      = (a_i[6] == b_eff[6]) && (sum[6] != a_i[6]);
            end
            3'b010:  result_o = a_i & b_i;
            3'b011:  result_o = a_i | b_i;
            3'b100:  result_o = {b_i[5:0], 1'b0};
            3'b101:  result_o = {1'b0, b_i[6:1]};
            default: err_o    = 1'b1;
        endcase
    end

    assign flags_o = {carry, ovf, (result_o == 7'd0), result_o[6]};
endmodule

module alu_sched #(
    parameter int CNT_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    alu_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [6:0]       a_q, a_d;
    logic [6:0]       b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             id_q, id_d;

    logic             rsp_id_q, rsp_id_d;
    logic [6:0]       rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             grant;
    logic             req0_rdy;
    logic             req1_rdy;
    logic [6:0]       alu_result;
    logic [3:0]       alu_flags;
    logic             alu_err;

    alu_sched_alu u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_result),
        .flags_o  (alu_flags),
        .err_o    (alu_err)
    );

    // Under contention the requester that did not win last time gets the slot.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_q;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        req0_rdy     = 1'b0;
        req1_rdy     = 1'b0;

        case (state_q)
            IDLE: begin
                req0_rdy = !rst && !grant;
                req1_rdy = !rst && grant;
                if (bus.req0_valid && req0_rdy) begin
                    a_d     = bus.req0_a;
                    b_d     = bus.req0_b;
                    op_d    = bus.req0_op;
                    id_d    = 1'b0;
                    last_d  = 1'b0;
                    state_d = EXEC;
                end else if (bus.req1_valid && req1_rdy) begin
                    a_d     = bus.req1_a;
                    b_d     = bus.req1_b;
                    op_d    = bus.req1_op;
                    id_d    = 1'b1;
                    last_d  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_id_d     = id_q;
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_flags;
                rsp_err_d    = alu_err;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    if (!rsp_id_q && (cnt0_q != {CNT_W{1'b1}})) begin
                        cnt0_d = cnt0_q + CNT_ONE;
                    end
                    if (rsp_id_q && (cnt1_q != {CNT_W{1'b1}})) begin
                        cnt1_d = cnt1_q + CNT_ONE;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            a_q          <= 7'd0;
            b_q          <= 7'd0;
            op_q         <= 3'd0;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 7'd0;
            rsp_flags_q  <= 4'd0;
            rsp_err_q    <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign bus.req0_ready = req0_rdy;
    assign bus.req1_ready = req1_rdy;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.cnt0       = cnt0_q;
    assign bus.cnt1       = cnt1_q;
endmodule
